rs_syndrome_gen: RTL and testbench
==================================

RS_SYNDROME_GEN -- requirements
Module: rs_syndrome_gen

Interface
REQ-001 Parameter NROOTS, default 4: number of parity symbols and syndromes; even, 2..16.
REQ-002 Parameter GEN_START, default 0: exponent of the first generator root alpha^GEN_START.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 running  input  1  enable; 0 forces IDLE.
REQ-006 encoding  input  1  1 = encode (parity generation), 0 = decode (syndrome calculation).
REQ-007 dataI  input  8  input symbol, GF(2^8).
REQ-008 valid  input  1  one-cycle symbol strobe.
REQ-009 blanking  input  1  qualifies valid; a blanked symbol is not accumulated.
REQ-010 endSegment  input  1  marks the strobed symbol as the last data symbol of a segment.
REQ-011 synOut  output  8*NROOTS  latched syndromes; S0 in bits [7:0].
REQ-012 synReady  output  1  one-cycle pulse when synOut is updated.
REQ-013 dataO  output  8  registered pass-through symbol or parity symbol.
REQ-014 oValid  output  1  one-cycle pulse qualifying dataO.
REQ-015 busy  output  1  high while in PAR_OUT.

Function
REQ-016 Field: GF(2^8), primitive polynomial 0x11D, alpha = 0x02; all multipliers constant, combinational.
REQ-017 States: IDLE, ACCUM, PAR_OUT; in IDLE, running=1 enters ACCUM next cycle and latches encoding; encoding is ignored outside IDLE.
REQ-018 ACCUM decode: on valid & !blanking, each S_i <= S_i*alpha^(GEN_START+i) xor dataI.
REQ-019 ACCUM encode: on valid & !blanking, the LFSR encoder of g(x)=prod(x-alpha^(GEN_START+i)), i=0..NROOTS-1, is updated with dataI.
REQ-020 ACCUM, either mode: on valid, dataO <= dataI and oValid pulses the following cycle (latency 1), blanked symbols included.
REQ-021 valid & endSegment in decode: synOut takes the final syndromes (last symbol included when not blanked), synReady pulses the following cycle, accumulators clear, state remains ACCUM.
REQ-022 valid & endSegment in encode: state enters PAR_OUT after the final symbol is accumulated.
REQ-023 PAR_OUT: each valid outputs the highest-order parity symbol on dataO with oValid (latency 1) and shifts the register; blanking and endSegment are ignored; after NROOTS outputs, the register clears and state returns to ACCUM.
REQ-024 endSegment without valid has no effect.
REQ-025 running=0 in any state: next cycle IDLE, accumulators and parity cleared, no synReady, synOut retained.
REQ-026 valid & blanking & endSegment: the segment ends and the blanked symbol is not accumulated.
REQ-027 Empty segment (endSegment on the first strobe, blanked): decode synOut all zero, synReady pulses.

Reset
REQ-028 reset=0 at a clock edge: state IDLE; synOut, dataO, accumulators and parity all 0; synReady, oValid, busy 0; mid-segment data discarded.

Configuration
REQ-029 RS_SYN_ZERO_FLAG_EN defined: adds output synZero (1 bit), registered and valid with synReady, 1 when all NROOTS syndromes are zero, reset 0.
REQ-030 RS_SYN_ZERO_FLAG_EN undefined: port synZero and its logic absent; all other behaviour identical.

Verification
REQ-031 NROOTS=4, GEN_START=0, decode, symbols 0x01 then 0x00 (endSegment) -> synReady; S0..S3 = 0x01,0x02,0x04,0x08.
REQ-032 Decode, 10 zero symbols, endSegment on the last -> synOut = 0, synZero=1 if enabled.
REQ-033 Encode 20 symbols ~i, then 4 PAR_OUT strobes; replay 24 symbols in decode -> all syndromes 0; flip bit 3 of symbol 5 -> syndromes nonzero, synZero=0.
REQ-034 Blanked symbols inserted mid-segment in decode -> syndromes equal those of the unblanked sequence; dataO still echoes each symbol.
REQ-035 reset=0 or running=0 mid-segment, then a fresh segment -> results match a clean run, no spurious synReady.

Source files
------------

// File: rtl/rs_syndrome_gen.sv
// rs_syndrome_gen: Reed-Solomon GF(2^8) syndrome calculator (decode) and parity generator (encode).
//   clk, reset        : rising-edge clock, synchronous active-low reset
//   running           : enable, low forces IDLE and clears accumulators
//   encoding          : mode latched on IDLE->ACCUM (1 = encode, 0 = decode)
//   dataI/valid       : input symbol and its one-cycle strobe
//   blanking          : strobed symbol is echoed but not accumulated
//   endSegment        : strobed symbol is the last data symbol of a segment
//   synOut/synReady   : latched syndromes (S0 in [7:0]) and update pulse
//   dataO/oValid      : echoed data or parity symbol and its strobe
//   busy              : parity is being emitted
//   synZero           : all syndromes zero, valid with synReady (only with RS_SYN_ZERO_FLAG_EN)
module rs_syndrome_gen #(
    parameter int NROOTS    = 4,
    parameter int GEN_START = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                running,
    input  logic                encoding,
    input  logic [7:0]          dataI,
    input  logic                valid,
    input  logic                blanking,
    input  logic                endSegment,
    output logic [8*NROOTS-1:0] synOut,
    output logic                synReady,
    output logic [7:0]          dataO,
    output logic                oValid,
`ifdef RS_SYN_ZERO_FLAG_EN
    output logic                synZero,
`endif
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, PAR_OUT} state_t;

    // Shift-and-add multiply modulo 0x11D; with one operand constant it reduces to xor trees.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < e % 255; k++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [8*NROOTS-1:0] root_vec();
        logic [8*NROOTS-1:0] r;
        for (int i = 0; i < NROOTS; i++) r[8*i +: 8] = gf_pow(GEN_START + i);
        return r;
    endfunction

    // Low NROOTS coefficients of the monic generator, built by multiplying in (x + root) one at a time.
    function automatic logic [8*NROOTS-1:0] gen_poly();
        logic [8*NROOTS+7:0] g;
        logic [7:0]          r;
        g = '0;
        g[7:0] = 8'h01;
        for (int i = 0; i < NROOTS; i++) begin
            r = gf_pow(GEN_START + i);
            for (int j = NROOTS; j > 0; j--) g[8*j +: 8] = g[8*(j-1) +: 8] ^ gf_mul(r, g[8*j +: 8]);
            g[7:0] = gf_mul(r, g[7:0]);
        end
        return g[8*NROOTS-1:0];
    endfunction

    localparam logic [8*NROOTS-1:0] ROOTS = root_vec();
    localparam logic [8*NROOTS-1:0] GEN   = gen_poly();

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [8*NROOTS-1:0] syn_q, syn_d, par_q, par_d, synOut_q, synOut_d;
    logic [8*NROOTS-1:0] syn_nx, par_nx, syn_fin;
    logic [4:0]          cnt_q, cnt_d;
    logic [7:0]          dataO_q, dataO_d, fb;
    logic                synReady_q, synReady_d, oValid_q, oValid_d, acc;
`ifdef RS_SYN_ZERO_FLAG_EN
    logic                synZero_q, synZero_d;
    assign synZero = synZero_q;
`endif

    assign synOut   = synOut_q;
    assign synReady = synReady_q;
    assign dataO    = dataO_q;
    assign oValid   = oValid_q;
    assign busy     = state_q == PAR_OUT;

    // Horner step for every syndrome and one step of the systematic division LFSR.
    always_comb begin
        fb = dataI ^ par_q[8*NROOTS-1 -: 8];
        par_nx[7:0] = gf_mul(fb, GEN[7:0]);
        for (int j = 1; j < NROOTS; j++) par_nx[8*j +: 8] = par_q[8*(j-1) +: 8] ^ gf_mul(fb, GEN[8*j +: 8]);
        for (int i = 0; i < NROOTS; i++) syn_nx[8*i +: 8] = gf_mul(syn_q[8*i +: 8], ROOTS[8*i +: 8]) ^ dataI;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        syn_d      = syn_q;
        par_d      = par_q;
        cnt_d      = cnt_q;
        synOut_d   = synOut_q;
        dataO_d    = dataO_q;
        synReady_d = 1'b0;
        oValid_d   = 1'b0;
        acc        = valid && !blanking;
        syn_fin    = acc ? syn_nx : syn_q;
`ifdef RS_SYN_ZERO_FLAG_EN
        synZero_d  = synZero_q;
`endif
        if (!running) begin
            state_d = IDLE;
            syn_d   = '0;
            par_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACCUM;
                    mode_d  = encoding;
                end
                ACCUM: if (valid) begin
                    dataO_d  = dataI;
                    oValid_d = 1'b1;
                    if (mode_q) begin
                        par_d   = acc ? par_nx : par_q;
                        cnt_d   = '0;
                        state_d = endSegment ? PAR_OUT : ACCUM;
                    end else if (endSegment) begin
                        synOut_d   = syn_fin;
                        synReady_d = 1'b1;
                        syn_d      = '0;
`ifdef RS_SYN_ZERO_FLAG_EN
                        synZero_d  = syn_fin == '0;
`endif
                    end else begin
                        syn_d = syn_fin;
                    end
                end
                PAR_OUT: if (valid) begin
                    // Highest-order parity first; shifting zeros in leaves the register clear at the end.
                    dataO_d  = par_q[8*NROOTS-1 -: 8];
                    oValid_d = 1'b1;
                    par_d    = par_q << 8;
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == 5'(NROOTS - 1)) begin
                        state_d = ACCUM;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            syn_q      <= '0;
            par_q      <= '0;
            cnt_q      <= '0;
            synOut_q   <= '0;
            dataO_q    <= '0;
            synReady_q <= 1'b0;
            oValid_q   <= 1'b0;
`ifdef RS_SYN_ZERO_FLAG_EN
            synZero_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            syn_q      <= syn_d;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            synOut_q   <= synOut_d;
            dataO_q    <= dataO_d;
            synReady_q <= synReady_d;
            oValid_q   <= oValid_d;
`ifdef RS_SYN_ZERO_FLAG_EN
            synZero_q  <= synZero_d;
`endif
        end
    end
endmodule

// File: tb/tb_rs_syndrome_gen.sv
// tb_rs_syndrome_gen: directed self-checking bench for rs_syndrome_gen (NROOTS=4, GEN_START=0).
module tb_rs_syndrome_gen;
    logic        clk = 1'b0, reset = 1'b0, running = 1'b0, encoding = 1'b0;
    logic        valid = 1'b0, blanking = 1'b0, endSegment = 1'b0;
    logic [7:0]  dataI = 8'h00;
    logic [31:0] synOut;
    logic        synReady, oValid, busy;
    logic [7:0]  dataO;
`ifdef RS_SYN_ZERO_FLAG_EN
    logic        synZero;
`endif
    int checks = 0, errors = 0;
    logic [7:0]  cw [0:23];

    rs_syndrome_gen #(.NROOTS(4), .GEN_START(0)) dut (
        .clk(clk), .reset(reset), .running(running), .encoding(encoding),
        .dataI(dataI), .valid(valid), .blanking(blanking), .endSegment(endSegment),
        .synOut(synOut), .synReady(synReady), .dataO(dataO), .oValid(oValid),
`ifdef RS_SYN_ZERO_FLAG_EN
        .synZero(synZero),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gpow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < e % 255; k++) r = gmul(r, 8'h02);
        return r;
    endfunction

    task automatic send(input logic [7:0] d, input logic b, input logic e);
        @(negedge clk);
        dataI = d; valid = 1'b1; blanking = b; endSegment = e;
        @(negedge clk);
        valid = 1'b0; blanking = 1'b0; endSegment = 1'b0;
    endtask

    task automatic start_seg(input logic enc);
        @(negedge clk);
        running = 1'b0;
        @(negedge clk);
        running = 1'b1; encoding = enc;
        @(negedge clk);
    endtask

    task automatic test_reset;
        running = 1'b1; valid = 1'b1; dataI = 8'h55; endSegment = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (synOut !== 32'h0) begin errors++; $display("FAIL reset_synOut got %h exp %h", synOut, 32'h0); end
        checks++; if (dataO !== 8'h00) begin errors++; $display("FAIL reset_dataO got %h exp 00", dataO); end
        checks++; if ({synReady, oValid, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {synReady, oValid, busy}); end
`ifdef RS_SYN_ZERO_FLAG_EN
        checks++; if (synZero !== 1'b0) begin errors++; $display("FAIL reset_synZero got %b exp 0", synZero); end
`endif
        valid = 1'b0; endSegment = 1'b0; running = 1'b0; dataI = 8'h00;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_decode_basic;
        start_seg(1'b0);
        send(8'h01, 1'b0, 1'b0);
        checks++; if ({oValid, dataO} !== {1'b1, 8'h01}) begin errors++; $display("FAIL dec_echo got %b/%h exp 1/01", oValid, dataO); end
        checks++; if (synReady !== 1'b0) begin errors++; $display("FAIL dec_early_ready got %b exp 0", synReady); end
        send(8'h00, 1'b0, 1'b1);
        checks++; if (synReady !== 1'b1) begin errors++; $display("FAIL dec_ready got %b exp 1", synReady); end
        checks++; if (synOut !== 32'h08040201) begin errors++; $display("FAIL dec_basic got %h exp 08040201", synOut); end
        @(negedge clk);
        checks++; if (synReady !== 1'b0) begin errors++; $display("FAIL dec_ready_pulse got %b exp 0", synReady); end
    endtask

    task automatic test_zero_segment;
        for (int i = 0; i < 10; i++) send(8'h00, 1'b0, i == 9);
        checks++; if ({synReady, synOut} !== {1'b1, 32'h0}) begin errors++; $display("FAIL zero_seg got %b/%h exp 1/00000000", synReady, synOut); end
`ifdef RS_SYN_ZERO_FLAG_EN
        checks++; if (synZero !== 1'b1) begin errors++; $display("FAIL zero_flag got %b exp 1", synZero); end
`endif
    endtask

    task automatic test_blanking;
        send(8'h03, 1'b0, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        checks++; if ({oValid, dataO} !== {1'b1, 8'hAA}) begin errors++; $display("FAIL blank_echo got %b/%h exp 1/aa", oValid, dataO); end
        send(8'h05, 1'b0, 1'b1);
        checks++; if (synOut !== 32'h1D090306) begin errors++; $display("FAIL blank_mid got %h exp 1d090306", synOut); end
        send(8'h01, 1'b0, 1'b0);
        send(8'h77, 1'b1, 1'b1);
        checks++; if ({synReady, synOut} !== {1'b1, 32'h01010101}) begin errors++; $display("FAIL blank_end got %b/%h exp 1/01010101", synReady, synOut); end
        send(8'h33, 1'b1, 1'b1);
        checks++; if ({synReady, synOut} !== {1'b1, 32'h0}) begin errors++; $display("FAIL empty_seg got %b/%h exp 1/00000000", synReady, synOut); end
    endtask

    task automatic test_end_no_valid;
        send(8'h01, 1'b0, 1'b0);
        @(negedge clk); endSegment = 1'b1;
        @(negedge clk); endSegment = 1'b0;
        checks++; if ({synReady, synOut} !== {1'b0, 32'h0}) begin errors++; $display("FAIL end_no_valid got %b/%h exp 0/00000000", synReady, synOut); end
        send(8'h00, 1'b0, 1'b1);
        checks++; if (synOut !== 32'h08040201) begin errors++; $display("FAIL end_no_valid_cont got %h exp 08040201", synOut); end
    endtask

    task automatic test_encode_single;
        logic [31:0] par;
        par = 32'h0F367840;
        start_seg(1'b1);
        send(8'h01, 1'b0, 1'b1);
        checks++; if ({oValid, dataO, busy, synReady} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin errors++; $display("FAIL enc_end got %b/%h/%b/%b exp 1/01/1/0", oValid, dataO, busy, synReady); end
        for (int k = 0; k < 4; k++) begin
            send(8'hC3, k == 1, k == 0);
            checks++; if ({oValid, dataO} !== {1'b1, par[31-8*k -: 8]}) begin errors++; $display("FAIL enc_par%0d got %b/%h exp 1/%h", k, oValid, dataO, par[31-8*k -: 8]); end
            checks++; if (busy !== (k < 3)) begin errors++; $display("FAIL enc_busy%0d got %b exp %b", k, busy, k < 3); end
        end
    endtask

    task automatic test_codeword;
        logic [7:0] s;
        logic [31:0] exp_syn;
        start_seg(1'b1);
        for (int i = 0; i < 20; i++) begin
            cw[i] = ~8'(i);
            send(cw[i], 1'b0, i == 19);
        end
        for (int k = 0; k < 4; k++) begin
            send(8'h00, 1'b0, 1'b0);
            cw[20 + k] = dataO;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cw_busy got %b exp 0", busy); end
        for (int i = 0; i < 4; i++) begin
            s = 8'h00;
            for (int k = 0; k < 24; k++) s ^= gmul(cw[k], gpow(i * (23 - k)));
            checks++; if (s !== 8'h00) begin errors++; $display("FAIL cw_parity_root%0d got %h exp 00", i, s); end
        end
        start_seg(1'b0);
        for (int k = 0; k < 24; k++) send(cw[k], 1'b0, k == 23);
        checks++; if ({synReady, synOut} !== {1'b1, 32'h0}) begin errors++; $display("FAIL cw_decode got %b/%h exp 1/00000000", synReady, synOut); end
        cw[5] ^= 8'h08;
        for (int k = 0; k < 24; k++) send(cw[k], 1'b0, k == 23);
        exp_syn = {gpow(57), gpow(39), gpow(21), 8'h08};
        checks++; if (synOut !== exp_syn) begin errors++; $display("FAIL cw_error got %h exp %h", synOut, exp_syn); end
`ifdef RS_SYN_ZERO_FLAG_EN
        checks++; if (synZero !== 1'b0) begin errors++; $display("FAIL cw_error_flag got %b exp 0", synZero); end
`endif
    endtask

    task automatic test_back_to_back;
        start_seg(1'b0);
        @(negedge clk); dataI = 8'h03; valid = 1'b1;
        @(negedge clk);
        checks++; if ({oValid, dataO, synReady} !== {1'b1, 8'h03, 1'b0}) begin errors++; $display("FAIL b2b_first got %b/%h/%b exp 1/03/0", oValid, dataO, synReady); end
        dataI = 8'h05; endSegment = 1'b1;
        @(negedge clk);
        checks++; if ({oValid, dataO, synReady, synOut} !== {1'b1, 8'h05, 1'b1, 32'h1D090306}) begin errors++; $display("FAIL b2b_end got %b/%h/%b/%h exp 1/05/1/1d090306", oValid, dataO, synReady, synOut); end
        valid = 1'b0; endSegment = 1'b0;
        @(negedge clk);
        checks++; if ({oValid, synReady} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", {oValid, synReady}); end
    endtask

    task automatic test_abort;
        send(8'h99, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b0);
        @(negedge clk); running = 1'b0;
        @(negedge clk);
        checks++; if ({synReady, synOut} !== {1'b0, 32'h1D090306}) begin errors++; $display("FAIL stop_retain got %b/%h exp 0/1d090306", synReady, synOut); end
        start_seg(1'b0);
        send(8'h01, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        checks++; if (synOut !== 32'h08040201) begin errors++; $display("FAIL stop_fresh got %h exp 08040201", synOut); end
        send(8'h99, 1'b0, 1'b0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        checks++; if ({synReady, oValid, dataO, synOut} !== {1'b0, 1'b0, 8'h00, 32'h0}) begin errors++; $display("FAIL midreset got %b/%b/%h/%h exp 0/0/00/00000000", synReady, oValid, dataO, synOut); end
        reset = 1'b1;
        start_seg(1'b0);
        send(8'h03, 1'b0, 1'b0);
        send(8'h05, 1'b0, 1'b1);
        checks++; if (synOut !== 32'h1D090306) begin errors++; $display("FAIL reset_fresh got %h exp 1d090306", synOut); end
        start_seg(1'b1);
        send(8'h01, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b0);
        @(negedge clk); running = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_parout got %b exp 0", busy); end
        start_seg(1'b1);
        send(8'h01, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b0);
        checks++; if (dataO !== 8'h0F) begin errors++; $display("FAIL stop_par_clear got %h exp 0f", dataO); end
    endtask

    initial begin
        test_reset;
        test_decode_basic;
        test_zero_segment;
        test_blanking;
        test_end_no_valid;
        test_encode_single;
        test_codeword;
        test_back_to_back;
        test_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
